// File: rtl/main_memory_server_pkg.sv
// Shared types and helpers for the main memory server.
// Covers operation/size enums, the server FSM states and the byte-lane arithmetic.
package main_memory_server_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    MM_IDLE    = 2'd0,
    MM_WAIT    = 2'd1,
    MM_RESPOND = 2'd2
  } main_memory_state_e;

  // Unknown size encodings count as misaligned so they never touch the array.
  function automatic logic mem_is_misaligned(memory_operation_size_e size, logic [1:0] lane);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lane[0];
      MEM_WORD: return |lane;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] mem_byte_enable(memory_operation_size_e size, logic [1:0] lane);
    case (size)
      MEM_BYTE: return 4'b0001 << lane;
      MEM_HALF: return 4'b0011 << lane;
      MEM_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] mem_store_lanes(memory_operation_size_e size, logic [31:0] word);
    case (size)
      MEM_BYTE: return {4{word[7:0]}};
      MEM_HALF: return {2{word[15:0]}};
      default:  return word;
    endcase
  endfunction

  function automatic logic [31:0] mem_load_extract(memory_operation_size_e size, logic [1:0] lane,
                                                   logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      MEM_BYTE: return {24'b0, shifted[7:0]};
      MEM_HALF: return {16'b0, shifted[15:0]};
      MEM_WORD: return word;
      default:  return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_memory_server_if.sv
// Request/response bus between a load/store or fetch requester and the memory server.
interface main_memory_server_if
  import main_memory_server_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0]        req_address;
  memory_operation_e      req_operation;
  memory_operation_size_e req_size;
  logic [XLEN-1:0]        req_store_word;
  logic                   req_valid;
  logic [XLEN-1:0]        req_loaded_word;
  logic                   req_fulfilled;

  modport server (
    input  req_address, req_operation, req_size, req_store_word, req_valid,
    output req_loaded_word, req_fulfilled
  );

  modport client (
    output req_address, req_operation, req_size, req_store_word, req_valid,
    input  req_loaded_word, req_fulfilled
  );

endinterface

// File: rtl/main_memory_server_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The array has no reset and starts uninitialised.
module byte_enable_ram #(
  parameter int    WIDTH     = 32,
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [WIDTH/8-1:0]       we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] array [DEPTH];

  // Read returns the pre-write contents; the server only consumes it for loads.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (we[i]) begin
          array[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= array[addr];
    end
  end

endmodule

// File: rtl/main_memory_server.sv
// Word-organised RAM server: accepts one request, waits LATENCY cycles, then performs
// a byte/half/word load or store and pulses req_fulfilled for one cycle.
module main_memory_server
  import main_memory_server_pkg::*;
#(
  parameter int    XLEN      = 32,
  parameter int    DEPTH     = 4096,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset_n,
  main_memory_server_if.server mem,
  output logic                 misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  main_memory_state_e     state, next_state;
  logic [CW-1:0]          wait_count;
  logic [AW+1:0]          addr_q;
  memory_operation_e      op_q;
  memory_operation_size_e size_q;
  logic [XLEN-1:0]        store_q;
  logic                   start_access;

  logic [AW+1:0]          acc_addr;
  memory_operation_e      acc_op;
  memory_operation_size_e acc_size;
  logic [XLEN-1:0]        acc_data;
  logic                   acc_misaligned;
  logic [XLEN/8-1:0]      ram_we;
  logic [XLEN-1:0]        ram_wdata;
  logic [XLEN-1:0]        ram_rdata;
  logic                   responding;
  logic                   misaligned_q;
  logic                   unused_addr_high;

  assign unused_addr_high = ^mem.req_address[XLEN-1:AW+2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MM_IDLE;
      wait_count <= '0;
      addr_q     <= '0;
      op_q       <= MEM_LOAD;
      size_q     <= MEM_BYTE;
      store_q    <= '0;
    end else begin
      state <= next_state;
      if (state == MM_IDLE && mem.req_valid) begin
        addr_q     <= mem.req_address[AW+1:0];
        op_q       <= mem.req_operation;
        size_q     <= mem.req_size;
        store_q    <= mem.req_store_word;
        wait_count <= CW'(LATENCY);
      end else if (state == MM_WAIT) begin
        wait_count <= wait_count - 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    start_access = 1'b0;
    case (state)
      MM_IDLE: begin
        if (mem.req_valid) begin
          if (LATENCY == 0) begin
            next_state   = MM_RESPOND;
            start_access = 1'b1;
          end else begin
            next_state = MM_WAIT;
          end
        end
      end
      MM_WAIT: begin
        if (wait_count == CW'(1)) begin
          next_state   = MM_RESPOND;
          start_access = 1'b1;
        end
      end
      MM_RESPOND: next_state = MM_IDLE;
      default:    next_state = MM_IDLE;
    endcase
  end

  // With zero latency the access is issued on the accept edge, so it must use the live request.
  always_comb begin
    if (state == MM_IDLE) begin
      acc_addr = mem.req_address[AW+1:0];
      acc_op   = mem.req_operation;
      acc_size = mem.req_size;
      acc_data = mem.req_store_word;
    end else begin
      acc_addr = addr_q;
      acc_op   = op_q;
      acc_size = size_q;
      acc_data = store_q;
    end
  end

  assign acc_misaligned = mem_is_misaligned(acc_size, acc_addr[1:0]);
  assign ram_wdata      = mem_store_lanes(acc_size, acc_data);
  assign ram_we         = (start_access && acc_op == MEM_STORE && !acc_misaligned)
                          ? mem_byte_enable(acc_size, acc_addr[1:0]) : '0;

  byte_enable_ram #(
    .WIDTH     (XLEN),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (start_access),
    .we    (ram_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign responding   = (state == MM_RESPOND);
  assign misaligned_q = mem_is_misaligned(size_q, addr_q[1:0]);

  assign mem.req_fulfilled   = responding;
  assign misaligned          = responding && misaligned_q;
  assign mem.req_loaded_word = (responding && op_q == MEM_LOAD && !misaligned_q)
                               ? mem_load_extract(size_q, addr_q[1:0], ram_rdata) : '0;

endmodule

// File: tb/tb_main_memory_server.sv
// Directed and randomized checks of main_memory_server against a byte-level memory model.
module tb_main_memory_server;
  import main_memory_server_pkg::*;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mis2, mis0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  main_memory_server_if #(.XLEN(32)) bus2 ();
  main_memory_server_if #(.XLEN(32)) bus0 ();

  main_memory_server #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(2), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .mem(bus2.server), .misaligned(mis2)
  );

  main_memory_server #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset_n(reset_n), .mem(bus0.server), .misaligned(mis0)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model memory: a request touches nbytes consecutive bytes starting at the lane.
  function automatic void model_apply(input int m, input memory_operation_e op,
                                      input memory_operation_size_e size, input logic [31:0] addr,
                                      input logic [31:0] data, output logic [31:0] exp_word,
                                      output bit exp_mis);
    int idx, lane, nbytes;
    idx  = int'((addr >> 2) % DEPTH);
    lane = int'(addr % 4);
    case (size)
      MEM_BYTE: nbytes = 1;
      MEM_HALF: nbytes = 2;
      MEM_WORD: nbytes = 4;
      default:  nbytes = 0;
    endcase
    if (nbytes == 0) exp_mis = 1'b1;
    else             exp_mis = (lane % nbytes) != 0;
    exp_word = '0;
    if (!exp_mis) begin
      for (int b = 0; b < nbytes; b++) begin
        if (op == MEM_STORE) mdl[m][idx][8*(lane+b) +: 8] = data[8*b +: 8];
        else                 exp_word[8*b +: 8] = mdl[m][idx][8*(lane+b) +: 8];
      end
    end
  endfunction

  task automatic apply_stimulus(input memory_operation_e op, input memory_operation_size_e size,
                                input logic [31:0] addr, input logic [31:0] data,
                                input string tag, output logic [31:0] got);
    logic [31:0] exp_word;
    bit          exp_mis;
    bit          seen;
    logic        got_mis;
    int          cyc;
    model_apply(0, op, size, addr, data, exp_word, exp_mis);
    @(negedge clk);
    bus2.req_address    = addr;
    bus2.req_operation  = op;
    bus2.req_size       = size;
    bus2.req_store_word = data;
    bus2.req_valid      = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    got  = '0;
    got_mis = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus2.req_fulfilled) begin
        seen    = 1'b1;
        got     = bus2.req_loaded_word;
        got_mis = mis2;
      end
    end
    bus2.req_valid = 1'b0;
    check_output({tag, ":fulfilled"}, 32'(seen), 32'd1);
    check_output({tag, ":latency"}, cyc, 32'd3);
    check_output({tag, ":loaded"}, got, exp_word);
    check_output({tag, ":misaligned"}, 32'(got_mis), 32'(exp_mis));
    @(posedge clk);
    #1;
    check_output({tag, ":pulse_end"}, 32'(bus2.req_fulfilled), 32'd0);
    check_output({tag, ":idle_word"}, bus2.req_loaded_word, 32'd0);
    check_output({tag, ":idle_mis"}, 32'(mis2), 32'd0);
  endtask

  initial begin : stimulus
    logic [31:0] got;
    int          fcount;
    memory_operation_e      t5_op   [16];
    memory_operation_size_e t5_size [16];
    logic [31:0]            t5_addr [16];
    logic [31:0]            t5_data [16];
    logic [31:0]            t5_exp  [16];
    bit                     t5_mis  [16];
    int k, cyc, last;

    bus2.req_valid = 1'b0; bus2.req_address = '0; bus2.req_operation = MEM_LOAD;
    bus2.req_size = MEM_WORD; bus2.req_store_word = '0;
    bus0.req_valid = 1'b0; bus0.req_address = '0; bus0.req_operation = MEM_LOAD;
    bus0.req_size = MEM_WORD; bus0.req_store_word = '0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_fulfilled", 32'(bus2.req_fulfilled), 32'd0);
    check_output("reset_loaded", bus2.req_loaded_word, 32'd0);
    check_output("reset_mis", 32'(mis2), 32'd0);
    check_output("reset0_fulfilled", 32'(bus0.req_fulfilled), 32'd0);
    check_output("reset0_loaded", bus0.req_loaded_word, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Word store then load.
    apply_stimulus(MEM_STORE, MEM_WORD, 32'h10, 32'hDEADBEEF, "t1_store", got);
    apply_stimulus(MEM_LOAD, MEM_WORD, 32'h10, 32'h0, "t1_load", got);
    check_output("t1_value", got, 32'hDEADBEEF);

    // Byte store into a known word, then word/byte/half loads.
    apply_stimulus(MEM_STORE, MEM_WORD, 32'h10, 32'h11223344, "t2_init", got);
    apply_stimulus(MEM_STORE, MEM_BYTE, 32'h13, 32'h000000AA, "t2_sb", got);
    apply_stimulus(MEM_LOAD, MEM_WORD, 32'h10, 32'h0, "t2_lw", got);
    check_output("t2_lw_value", got, 32'hAA223344);
    apply_stimulus(MEM_LOAD, MEM_BYTE, 32'h13, 32'h0, "t2_lb", got);
    check_output("t2_lb_value", got, 32'h000000AA);
    apply_stimulus(MEM_LOAD, MEM_HALF, 32'h12, 32'h0, "t2_lh", got);
    check_output("t2_lh_value", got, 32'h0000AA22);

    // Misaligned and unknown-size requests complete without writing.
    apply_stimulus(MEM_LOAD, MEM_HALF, 32'h11, 32'h0, "t3_lh_mis", got);
    apply_stimulus(MEM_STORE, MEM_WORD, 32'h12, 32'hFFFFFFFF, "t3_sw_mis", got);
    apply_stimulus(MEM_STORE, memory_operation_size_e'(2'b11), 32'h10, 32'h0, "t3_bad_size", got);
    apply_stimulus(MEM_LOAD, MEM_WORD, 32'h10, 32'h0, "t3_lw", got);
    check_output("t3_unchanged", got, 32'hAA223344);

    // Address wrap modulo DEPTH*4.
    apply_stimulus(MEM_STORE, MEM_WORD, 32'h4004, 32'h5A5A5A5A, "t4_store", got);
    apply_stimulus(MEM_LOAD, MEM_WORD, 32'h4, 32'h0, "t4_load", got);
    check_output("t4_value", got, 32'h5A5A5A5A);

    // Reset during WAIT drops the in-flight store.
    apply_stimulus(MEM_STORE, MEM_WORD, 32'h20, 32'hCAFEF00D, "t6_init", got);
    @(negedge clk);
    bus2.req_address = 32'h20; bus2.req_operation = MEM_STORE;
    bus2.req_size = MEM_WORD; bus2.req_store_word = 32'h12345678; bus2.req_valid = 1'b1;
    @(posedge clk);
    #1;
    check_output("t6_waiting", 32'(bus2.req_fulfilled), 32'd0);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_fulfilled", 32'(bus2.req_fulfilled), 32'd0);
    check_output("t6_rst_loaded", bus2.req_loaded_word, 32'd0);
    check_output("t6_rst_mis", 32'(mis2), 32'd0);
    bus2.req_valid = 1'b0;
    fcount = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus2.req_fulfilled) fcount++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus2.req_fulfilled) fcount++;
    end
    check_output("t6_no_pulse", fcount, 32'd0);
    apply_stimulus(MEM_LOAD, MEM_WORD, 32'h20, 32'h0, "t6_load", got);
    check_output("t6_old_value", got, 32'hCAFEF00D);

    // Zero-latency server, back-to-back with valid held high.
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        t5_op[i] = MEM_STORE; t5_size[i] = MEM_WORD;
        t5_addr[i] = 32'((40 + i) * 4); t5_data[i] = $urandom;
      end else begin
        t5_op[i] = MEM_LOAD;
        t5_size[i] = memory_operation_size_e'(2'($urandom_range(0, 2)));
        t5_addr[i] = 32'((40 + $urandom_range(0, 7)) * 4 + $urandom_range(0, 3));
        t5_data[i] = '0;
      end
    end
    @(negedge clk);
    model_apply(1, t5_op[0], t5_size[0], t5_addr[0], t5_data[0], t5_exp[0], t5_mis[0]);
    bus0.req_address = t5_addr[0]; bus0.req_operation = t5_op[0];
    bus0.req_size = t5_size[0]; bus0.req_store_word = t5_data[0]; bus0.req_valid = 1'b1;
    k = 0; cyc = 0; last = -1;
    while (k < 16 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus0.req_fulfilled) begin
        check_output($sformatf("t5_loaded_%0d", k), bus0.req_loaded_word, t5_exp[k]);
        check_output($sformatf("t5_mis_%0d", k), 32'(mis0), 32'(t5_mis[k]));
        if (last >= 0) check_output($sformatf("t5_gap_%0d", k), cyc - last, 32'd2);
        last = cyc;
        k++;
        if (k < 16) begin
          model_apply(1, t5_op[k], t5_size[k], t5_addr[k], t5_data[k], t5_exp[k], t5_mis[k]);
          bus0.req_address = t5_addr[k]; bus0.req_operation = t5_op[k];
          bus0.req_size = t5_size[k]; bus0.req_store_word = t5_data[k];
        end else begin
          bus0.req_valid = 1'b0;
        end
      end
    end
    bus0.req_valid = 1'b0;
    check_output("t5_completed", k, 32'd16);

    // Randomized traffic over a preloaded window, including wrapped aliases and bad sizes.
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(MEM_STORE, MEM_WORD, 32'(i * 4), $urandom, "rnd_preload", got);
    end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      addr = 32'($urandom_range(0, 3) << 14) | 32'($urandom_range(0, 31) * 4)
             | 32'($urandom_range(0, 3));
      apply_stimulus(memory_operation_e'($urandom_range(0, 1)),
                     memory_operation_size_e'(2'($urandom_range(0, 3))),
                     addr, $urandom, $sformatf("rnd_%0d", i), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
